// File: rtl/mc_control_alu_if.sv
// Bus bundle for the multicycle control/ALU core.
// master drives instruction and operands; slave is the core.
interface mc_control_alu_if;
    logic [31:0] instr;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [31:0] pcQ;
    logic [31:0] aluResult;
    logic        zero;
    logic [31:0] pcPlus4;
    logic [4:0]  aluControl;
    logic        IorD;
    logic        ALUSrcA;
    logic        regDst;
    logic        memToReg;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSrc;
    logic        IRWrite;
    logic        memWrite;
    logic        regWriteEnable;
    logic        PCWrite;
    logic        branchEnable;
    logic        jump;
    logic        jumpReg;
    logic        PCWriteEn;
    logic [3:0]  state;

    modport master (
        output instr, srcA, srcB, pcQ,
        input  aluResult, zero, pcPlus4, aluControl,
        input  IorD, ALUSrcA, regDst, memToReg, ALUSrcB, PCSrc,
        input  IRWrite, memWrite, regWriteEnable, PCWrite,
        input  branchEnable, jump, jumpReg, PCWriteEn, state
    );

    modport slave (
        input  instr, srcA, srcB, pcQ,
        output aluResult, zero, pcPlus4, aluControl,
        output IorD, ALUSrcA, regDst, memToReg, ALUSrcB, PCSrc,
        output IRWrite, memWrite, regWriteEnable, PCWrite,
        output branchEnable, jump, jumpReg, PCWriteEn, state
    );
endinterface

// File: rtl/mc_control_alu.sv
// Multicycle MIPS-subset control FSM, 32-bit ALU and PC+4 adder.
// Outputs are decoded combinationally from the current state and instr.
module mc_control_alu (
    input logic              clock,
    input logic              reset,
    mc_control_alu_if.slave  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12
    } state_t;

    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_XOR = 5'b00011;
    localparam logic [4:0] ALU_NOR = 5'b01100;
    localparam logic [4:0] ALU_SLT = 5'b00111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t      state_q;
    state_t      state_d;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  funct_ctl;
    logic [4:0]  alu_ctl;
    logic [31:0] alu_res;
    logic        irwrite_raw;
    logic        memwrite_raw;
    logic        regwrite_raw;
    logic        pcwrite_raw;
    logic        branch_en;

    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];

    // Next-state selection; DECODE dispatches on opcode/funct.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = (funct == FN_JR) ? S_JR : S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // R-type funct to ALU operation; unknown functs execute as add.
    always_comb begin
        funct_ctl = ALU_ADD;
        case (funct)
            6'b100010: funct_ctl = ALU_SUB;
            6'b100100: funct_ctl = ALU_AND;
            6'b100101: funct_ctl = ALU_OR;
            6'b100110: funct_ctl = ALU_XOR;
            6'b100111: funct_ctl = ALU_NOR;
            6'b101010: funct_ctl = ALU_SLT;
            default:   funct_ctl = ALU_ADD;
        endcase
    end

    // Moore control decode; write enables are gated by reset below.
    always_comb begin
        bus.IorD       = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.regDst     = 1'b0;
        bus.memToReg   = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.PCSrc      = 2'b00;
        bus.jump       = 1'b0;
        bus.jumpReg    = 1'b0;
        alu_ctl        = ALU_ADD;
        irwrite_raw    = 1'b0;
        memwrite_raw   = 1'b0;
        regwrite_raw   = 1'b0;
        pcwrite_raw    = 1'b0;
        branch_en      = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.ALUSrcB = 2'b01;
                irwrite_raw = 1'b1;
                pcwrite_raw = 1'b1;
            end
            S_DECODE: bus.ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            S_MEMREAD: bus.IorD = 1'b1;
            S_MEMWB: begin
                bus.memToReg = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_MEMWRITE: begin
                bus.IorD     = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_EXECUTE: begin
                bus.ALUSrcA = 1'b1;
                alu_ctl     = funct_ctl;
            end
            S_ALUWB: begin
                bus.regDst   = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA = 1'b1;
                alu_ctl     = ALU_SUB;
                bus.PCSrc   = 2'b01;
                branch_en   = 1'b1;
            end
            S_ADDIWB: regwrite_raw = 1'b1;
            S_JUMP: begin
                bus.PCSrc   = 2'b10;
                pcwrite_raw = 1'b1;
                bus.jump    = 1'b1;
            end
            S_JR: begin
                bus.PCSrc   = 2'b11;
                pcwrite_raw = 1'b1;
                bus.jumpReg = 1'b1;
            end
            default: ;
        endcase
    end

    // 32-bit ALU; add/sub wrap, slt is signed.
    always_comb begin
        alu_res = 32'd0;
        case (alu_ctl)
            ALU_ADD: alu_res = bus.srcA + bus.srcB;
            ALU_SUB: alu_res = bus.srcA - bus.srcB;
            ALU_AND: alu_res = bus.srcA & bus.srcB;
            ALU_OR:  alu_res = bus.srcA | bus.srcB;
            ALU_XOR: alu_res = bus.srcA ^ bus.srcB;
            ALU_NOR: alu_res = ~(bus.srcA | bus.srcB);
            ALU_SLT: alu_res = ($signed(bus.srcA) < $signed(bus.srcB)) ? 32'd1 : 32'd0;
            default: alu_res = 32'd0;
        endcase
    end

    assign bus.aluResult      = alu_res;
    assign bus.zero           = (alu_res == 32'd0);
    assign bus.aluControl     = alu_ctl;
    assign bus.pcPlus4        = bus.pcQ + 32'd4;
    assign bus.branchEnable   = branch_en;
    assign bus.IRWrite        = irwrite_raw & ~reset;
    assign bus.memWrite       = memwrite_raw & ~reset;
    assign bus.regWriteEnable = regwrite_raw & ~reset;
    assign bus.PCWrite        = pcwrite_raw & ~reset;
    assign bus.PCWriteEn      = ~reset & (pcwrite_raw | (branch_en & bus.zero));
    assign bus.state          = state_q;

endmodule

// File: tb/tb_mc_control_alu.sv
// Bench for mc_control_alu: instruction-level reference model
// (per-instruction state paths) plus directed literal checks.
module tb_mc_control_alu;

    logic clock;
    logic reset;

    mc_control_alu_if ifc ();

    mc_control_alu dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_checks;
    int          n_fail;
    int          q[$];
    bit          known;
    logic [31:0] cur_instr;
    logic [31:0] next_instr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sequence of states visited by one whole instruction.
    function automatic void build_path(input logic [31:0] ins);
        case (ins[31:26])
            6'h23: q = '{0, 1, 2, 3, 4};
            6'h2B: q = '{0, 1, 2, 5};
            6'h00: if (ins[5:0] == 6'h08) q = '{0, 1, 12};
                   else q = '{0, 1, 6, 7};
            6'h04: q = '{0, 1, 8};
            6'h08: q = '{0, 1, 9, 10};
            6'h02: q = '{0, 1, 11};
            default: q = '{0, 1};
        endcase
    endfunction

    // Bench-side op ids: 0 add,1 sub,2 and,3 or,4 xor,5 nor,6 slt
    function automatic int funct_op(input logic [5:0] f);
        case (f)
            6'h22: return 1;
            6'h24: return 2;
            6'h25: return 3;
            6'h26: return 4;
            6'h27: return 5;
            6'h2A: return 6;
            default: return 0;
        endcase
    endfunction

    function automatic logic [4:0] op_code(input int op);
        logic [4:0] t [7];
        t = '{5'b00010, 5'b00110, 5'b00000, 5'b00001,
              5'b00011, 5'b01100, 5'b00111};
        return t[op];
    endfunction

    function automatic logic [31:0] op_eval(input int op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            0: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            1: return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ~(a | b);
            default: return (sa < sb) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // One cycle: advance model at the edge, then apply inputs.
    task automatic cyc(input logic r, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc);
        @(posedge clock);
        #1;
        if (reset) begin
            q.delete();
            known = 1'b1;
        end else if (known && q.size() > 0) begin
            void'(q.pop_front());
        end
        if (known && q.size() == 0) begin
            cur_instr = next_instr;
            build_path(cur_instr);
        end
        reset    = r;
        ifc.instr = cur_instr;
        ifc.srcA = a;
        ifc.srcB = b;
        ifc.pcQ  = pc;
        @(negedge clock);
    endtask

    // Per-cycle comparison against the instruction-level model.
    always @(negedge clock) begin
        if (known) begin
            if (q.size() == 0) begin
                chk("model_empty", 32'd1, 32'd0);
            end else begin
                int          s;
                int          op;
                logic        en;
                logic [31:0] res;
                logic        z;
                s  = q[0];
                en = ~reset;
                op = (s == 6) ? funct_op(cur_instr[5:0]) : ((s == 8) ? 1 : 0);
                res = op_eval(op, ifc.srcA, ifc.srcB);
                z = (res == 32'd0);
                chk("state", 32'(ifc.state), 32'(s));
                chk("aluControl", 32'(ifc.aluControl), 32'(op_code(op)));
                chk("aluResult", ifc.aluResult, res);
                chk("zero", 32'(ifc.zero), 32'(z));
                chk("pcPlus4", ifc.pcPlus4, ifc.pcQ + 32'd4);
                chk("IorD", 32'(ifc.IorD), 32'(s == 3 || s == 5));
                chk("ALUSrcA", 32'(ifc.ALUSrcA),
                    32'(s == 2 || s == 6 || s == 8 || s == 9));
                chk("ALUSrcB", 32'(ifc.ALUSrcB),
                    (s == 0) ? 1 : (s == 1) ? 3 : (s == 2 || s == 9) ? 2 : 0);
                chk("regDst", 32'(ifc.regDst), 32'(s == 7));
                chk("memToReg", 32'(ifc.memToReg), 32'(s == 4));
                chk("PCSrc", 32'(ifc.PCSrc),
                    (s == 8) ? 1 : (s == 11) ? 2 : (s == 12) ? 3 : 0);
                chk("IRWrite", 32'(ifc.IRWrite), 32'(en && s == 0));
                chk("memWrite", 32'(ifc.memWrite), 32'(en && s == 5));
                chk("regWriteEnable", 32'(ifc.regWriteEnable),
                    32'(en && (s == 4 || s == 7 || s == 10)));
                chk("PCWrite", 32'(ifc.PCWrite),
                    32'(en && (s == 0 || s == 11 || s == 12)));
                chk("branchEnable", 32'(ifc.branchEnable), 32'(s == 8));
                chk("jump", 32'(ifc.jump), 32'(s == 11));
                chk("jumpReg", 32'(ifc.jumpReg), 32'(s == 12));
                chk("PCWriteEn", 32'(ifc.PCWriteEn),
                    32'(en && (s == 0 || s == 11 || s == 12 || (s == 8 && z))));
            end
        end
    end

    initial begin
        logic [5:0] ops [8];
        logic [5:0] fns [9];
        n_checks   = 0;
        n_fail     = 0;
        known      = 1'b0;
        reset      = 1'b1;
        cur_instr  = 32'h0;
        next_instr = 32'h8C010004;
        ifc.instr  = 32'h0;
        ifc.srcA   = 32'h0;
        ifc.srcB   = 32'h0;
        ifc.pcQ    = 32'h0;

        // Reset for two cycles
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 32'd3, 32'd4, 32'h100);
            chk("rst_state", 32'(ifc.state), 32'd0);
            chk("rst_enables", {27'd0, ifc.IRWrite, ifc.memWrite,
                ifc.regWriteEnable, ifc.PCWrite, ifc.PCWriteEn}, 32'd0);
        end
        // lw: 0,1,2,3,4
        cyc(1'b0, 32'h100, 32'd4, 32'h100);
        chk("fetch_irw_pcw", {30'd0, ifc.IRWrite, ifc.PCWrite}, 32'd3);
        chk("fetch_pc4", ifc.aluResult, 32'h104);
        for (int i = 1; i < 5; i++) begin
            cyc(1'b0, 32'd8, 32'd4, 32'h104);
            chk("lw_state", 32'(ifc.state), 32'(i));
        end
        chk("lw_wb", {30'd0, ifc.regWriteEnable, ifc.memToReg}, 32'd3);

        // add
        next_instr = 32'h00430820;
        cyc(1'b0, 32'd0, 32'd4, 32'h0);
        cyc(1'b0, 32'd0, 32'd4, 32'h0);
        cyc(1'b0, 32'd5, 32'd7, 32'h0);
        chk("add_5_7", ifc.aluResult, 32'd12);
        cyc(1'b0, 32'd5, 32'd7, 32'h0);
        chk("alu_wb_regdst", 32'(ifc.regDst), 32'd1);

        // slt -1 < 1
        next_instr = 32'h0043082A;
        cyc(1'b0, 32'd0, 32'd4, 32'h0);
        cyc(1'b0, 32'd0, 32'd4, 32'h0);
        cyc(1'b0, 32'hFFFFFFFF, 32'd1, 32'h0);
        chk("slt_neg", ifc.aluResult, 32'd1);
        cyc(1'b0, 32'd0, 32'd0, 32'h0);

        // beq taken then not taken
        next_instr = 32'h10220003;
        cyc(1'b0, 32'hFFFFFFFF, 32'd1, 32'h0);
        chk("add_wrap_zero", {ifc.aluResult[30:0], ifc.zero}, 32'd1);
        cyc(1'b0, 32'd0, 32'd4, 32'h0);
        cyc(1'b0, 32'd9, 32'd9, 32'h0);
        chk("beq_taken", {29'd0, ifc.PCWriteEn, ifc.PCSrc}, 32'd5);
        cyc(1'b0, 32'd0, 32'd4, 32'h0);
        chk("beq_3cyc", 32'(ifc.state), 32'd0);
        cyc(1'b0, 32'd0, 32'd4, 32'h0);
        cyc(1'b0, 32'd0, 32'd1, 32'h0);
        chk("sub_0_1", ifc.aluResult, 32'hFFFFFFFF);
        chk("beq_not_taken", 32'(ifc.PCWriteEn), 32'd0);

        // j then jr
        next_instr = 32'h08000010;
        cyc(1'b0, 32'd0, 32'd4, 32'hFFFFFFFC);
        chk("pc4_wrap", ifc.pcPlus4, 32'd0);
        cyc(1'b0, 32'd0, 32'd4, 32'h0);
        cyc(1'b0, 32'd0, 32'd4, 32'h0);
        chk("jump", {29'd0, ifc.jump, ifc.PCSrc}, 32'd6);
        next_instr = 32'h03E00008;
        cyc(1'b0, 32'd0, 32'd4, 32'h0);
        cyc(1'b0, 32'd0, 32'd4, 32'h0);
        cyc(1'b0, 32'd0, 32'd4, 32'h0);
        chk("jr", {28'd0, ifc.state}, 32'd12);
        chk("jr_flag", 32'(ifc.jumpReg), 32'd1);

        // nor 0,0
        next_instr = 32'h00000027;
        cyc(1'b0, 32'd0, 32'd4, 32'h0);
        chk("jr_back", 32'(ifc.state), 32'd0);
        cyc(1'b0, 32'd0, 32'd4, 32'h0);
        cyc(1'b0, 32'd0, 32'd0, 32'h0);
        chk("nor_0_0", ifc.aluResult, 32'hFFFFFFFF);

        // Randomized instruction stream with occasional reset
        ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h08, 6'h02, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h08, 6'h3F};
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [5:0]  op;
            logic [5:0]  fn;
            op = ops[$urandom_range(0, 7)];
            if (op == 6'h3F) op = 6'($urandom);
            fn = fns[$urandom_range(0, 8)];
            if (fn == 6'h3F) fn = 6'($urandom);
            next_instr = {op, 20'($urandom), fn};
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0 - a;
            cyc($urandom_range(0, 49) == 0, a, b, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
